majority_window: RTL
====================

Name: majority_window

Overview:
- Parametrised, clocked successor to the combinational N-bit majority voter.
- Accepts a bit-serial sample stream and keeps a sliding window of the last W valid samples.
- Maintains a running count of ones and flags majority/threshold status once the window is full.
- Sits downstream of noisy single-bit sources (debounced inputs, link-quality bits) as a decision filter.

Parameters:
- W, 8, window depth in samples; legal range 2..64.
- THRESH, W/2+1, minimum ones-count for maj=1; legal range 1..W.
- HYST, 1, hysteresis width in counts; used only when MAJ_HYST_EN is defined; legal range 0..THRESH-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous window clear
- din  in  1  sample bit
- din_valid  in  1  sample qualifier
- count  out  $clog2(W+1)  ones in the current window
- maj  out  1  majority decision
- maj_valid  out  1  window full; maj is meaningful
- maj_change  out  1  one-cycle pulse when maj toggles while maj_valid=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - window shift register, count, fill counter, maj, maj_valid and maj_change all go to 0.
  - FSM enters FILL.
- Storage:
  - W-bit shift register plus fill counter of $clog2(W+1) bits, saturating at W.
- FSM states:
  - FILL: fewer than W samples accepted since reset or clr.
  - RUN: window full.
  - FILL->RUN on the din_valid cycle that brings the fill counter to W.
  - RUN->FILL only on clr.
- Accept (din_valid=1, clr=0):
  - din shifts in; the oldest bit shifts out.
  - FILL: count_next = count + din.
  - RUN: count_next = count + din - oldest.
  - Arithmetic is unsigned at count width; it cannot overflow or underflow by construction.
- Hold (din_valid=0, clr=0): all state and outputs hold; maj_change=0.
- Latency: all outputs are registered and reflect the accepted sample on the cycle after the accepting edge.
- maj_valid: 1 from the cycle the fill counter reaches W; stays 1 until clr or reset.
- maj:
  - In FILL, held at 0.
  - On the FILL->RUN transition: maj = (count_next >= THRESH).
  - In RUN without the optional feature: maj = (count_next >= THRESH) on every accept.
- maj_change:
  - 1 for exactly one cycle when the registered maj differs from its previous value and the previous cycle already had maj_valid=1.
  - The FILL->RUN transition never pulses maj_change.
- clr=1:
  - Next edge zeroes the window, count, fill counter, maj, maj_valid and maj_change; FSM returns to FILL.
  - clr has priority over a simultaneous din_valid; that sample is discarded.
- rst_n asserted mid-stream: immediate clear, same values as above; no partial-window state survives.
- Boundary cases:
  - THRESH=W: maj requires all ones.
  - THRESH=1: maj=1 on any one in the window.
  - din_valid on every cycle is supported at full throughput; there is no backpressure.

Optional Feature:
- Macro MAJ_HYST_EN.
- Defined: in RUN, maj sets when count_next >= THRESH and clears only when count_next < THRESH-HYST; otherwise maj holds. The FILL->RUN decision uses the set rule only.
- Undefined: HYST is ignored; set and clear use the single threshold THRESH as above.
- Port list is identical in both builds.

Test Plan:
- Reset, then idle 5 cycles -> count=0, maj=0, maj_valid=0, maj_change=0 throughout.
- W=4, THRESH=3; accept 1,1,1,0 on consecutive cycles:
  - maj_valid=0 after the first three samples; count=1,2,3.
  - After the 4th: maj_valid=1, count=3, maj=1, maj_change=0.
- Continue the previous stream with 0:
  - Oldest 1 leaves; count=2, maj=0, maj_change=1 for one cycle.
  - A further 0 gives count=1, maj_change=0.
- In RUN, hold din_valid=0 for 3 cycles with din toggling -> count, maj and maj_valid unchanged.
- In RUN with count=3, assert clr together with din_valid=1, din=1 -> next cycle count=0, maj_valid=0, maj=0. The sample is dropped; W further samples are needed to reach maj_valid=1 again.
- MAJ_HYST_EN defined, W=4, THRESH=3, HYST=1; window full at count=3 (maj=1):
  - Drop to count=2 -> maj stays 1.
  - Drop to count=1 -> maj=0 with a maj_change pulse.
  - Rise to count=2 -> maj stays 0.
  - Also: rst_n low mid-RUN clears all outputs asynchronously, without waiting for clk.

Source files
------------

// File: rtl/majority_window_if.sv
// Sample-stream and decision bundle for majority_window.
// The slave side is the filter; the master side feeds samples and watches the decision.
interface majority_window_if #(
    parameter int unsigned W = 8
);
    localparam int unsigned CW = $clog2(W + 1);

    logic          clr;
    logic          din;
    logic          din_valid;
    logic [CW-1:0] count;
    logic          maj;
    logic          maj_valid;
    logic          maj_change;

    modport master (
        output clr, din, din_valid,
        input  count, maj, maj_valid, maj_change
    );

    modport slave (
        input  clr, din, din_valid,
        output count, maj, maj_valid, maj_change
    );
endinterface

// File: rtl/majority_window.sv
// Sliding-window majority filter over the last W accepted samples.
// Optional macro MAJ_HYST_EN adds a HYST-count hysteresis band to the clear decision in RUN.
module majority_window #(
    parameter int unsigned W      = 8,
    parameter int unsigned THRESH = W / 2 + 1,
    parameter int unsigned HYST   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    majority_window_if.slave bus
);
    localparam int unsigned   CW       = $clog2(W + 1);
    localparam logic [CW-1:0] W_C      = CW'(W);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
`ifdef MAJ_HYST_EN
    localparam logic [CW-1:0] CLR_LVL  = CW'(THRESH - HYST);
`endif

    // Elaboration-time range guards.
    if (W < 2 || W > 64) begin : g_bad_w
        $error("majority_window: W out of range 2..64");
    end
    if (THRESH < 1 || THRESH > W) begin : g_bad_thresh
        $error("majority_window: THRESH out of range 1..W");
    end
    if (HYST >= THRESH) begin : g_bad_hyst
        $error("majority_window: HYST must be below THRESH");
    end

    typedef enum logic [0:0] {StFill, StRun} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  window_q, window_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          maj_q, maj_d;
    logic          valid_q, valid_d;
    logic          change_q, change_d;

    logic [CW-1:0] din_ext;
    logic [CW-1:0] old_ext;

    assign din_ext = {{(CW-1){1'b0}}, bus.din};
    assign old_ext = {{(CW-1){1'b0}}, window_q[W-1]};

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        count_d  = count_q;
        fill_d   = fill_q;
        maj_d    = maj_q;
        valid_d  = valid_q;
        change_d = 1'b0;

        if (bus.clr) begin
            // Clear wins over a same-cycle sample, which is dropped.
            state_d  = StFill;
            window_d = '0;
            count_d  = '0;
            fill_d   = '0;
            maj_d    = 1'b0;
            valid_d  = 1'b0;
        end else if (bus.din_valid) begin
            window_d = {window_q[W-2:0], bus.din};
            unique case (state_q)
                StFill: begin
                    count_d = count_q + din_ext;
                    fill_d  = fill_q + CW'(1);
                    if (fill_d == W_C) begin
                        // Entering RUN takes the set rule only and never pulses maj_change.
                        state_d = StRun;
                        valid_d = 1'b1;
                        maj_d   = (count_d >= THRESH_C);
                    end
                end
                StRun: begin
                    count_d = count_q + din_ext - old_ext;
`ifdef MAJ_HYST_EN
                    if (count_d >= THRESH_C) begin
                        maj_d = 1'b1;
                    end else if (count_d < CLR_LVL) begin
                        maj_d = 1'b0;
                    end
`else
                    maj_d = (count_d >= THRESH_C);
`endif
                    change_d = (maj_d != maj_q);
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFill;
            window_q <= '0;
            count_q  <= '0;
            fill_q   <= '0;
            maj_q    <= 1'b0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            count_q  <= count_d;
            fill_q   <= fill_d;
            maj_q    <= maj_d;
            valid_q  <= valid_d;
            change_q <= change_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.maj        = maj_q;
    assign bus.maj_valid  = valid_q;
    assign bus.maj_change = change_q;
endmodule
